atomic_counter_bank: RTL

Parametrised bank of NUM_CNT free-running event counters, each CNT_W bits wide, read out over a narrower BUS_W-bit register bus in CNT_W/BUS_W consecutive beats. The first beat of a read atomically snapshots the whole selected counter, so the later beats return upper slices that are consistent with the lower slice despite ongoing increments. It sits between per-event trigger sources and the status/CSR read path. It succeeds the single-channel 64/32 atomic counter.

---
 rtl/atomic_cnt_pkg.sv | 19 +
 rtl/atomic_cnt_channel.sv | 50 +++++
 rtl/atomic_counter_bank.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/atomic_cnt_pkg.sv
// Shared definitions for the atomic counter bank: default sizing,
// read-FSM state encoding and an index-width helper.
package atomic_cnt_pkg;

    localparam int DEF_NUM_CNT = 4;
    localparam int DEF_CNT_W   = 64;
    localparam int DEF_BUS_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Width of an index over n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atomic_cnt_channel.sv
// One event counter channel: free-running increment, wrap detection and
// sticky overflow flag. The clr input marks an atomic read of this channel;
// it always re-arms the overflow flag and, when ATOMIC_CNT_CLR_ON_READ_EN
// is defined, also restarts the count (keeping the same-cycle increment).
module atomic_cnt_channel
    import atomic_cnt_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             clr,
    output logic [CNT_W-1:0] inc_val,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             wrap;

    // Value the counter takes this cycle without a clear; also the snapshot source.
    assign inc_val = cnt_q + CNT_W'(trig);
    assign wrap    = trig && (&cnt_q);
    assign ovf     = ovf_q;

    // Counter and sticky overflow; a wrap on the read cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
`ifdef ATOMIC_CNT_CLR_ON_READ_EN
            if (clr) begin
                cnt_q <= CNT_W'(trig);
            end else begin
                cnt_q <= inc_val;
            end
`else
            cnt_q <= inc_val;
`endif
            if (clr) begin
                ovf_q <= wrap;
            end else begin
                ovf_q <= ovf_q | wrap;
            end
        end
    end

endmodule

// File: rtl/atomic_counter_bank.sv
// Bank of NUM_CNT event counters read over a BUS_W-bit bus in BEATS beats.
// The atomic first beat snapshots the whole selected counter so the later
// beats return slices consistent with the first one.
// Optional feature macro: ATOMIC_CNT_CLR_ON_READ_EN (clear counter on atomic read).
//
// Handshake: every cycle with req_i high is one beat and is answered on the
// same sampling edge with ack_o=1 (no stalls, no back-pressure); err_o marks
// a beat that has no valid data (count_o is then 0). req_i low gives ack_o=0
// and aborts any read in progress.
module atomic_counter_bank
    import atomic_cnt_pkg::*;
#(
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BUS_W   = DEF_BUS_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CNT-1:0]         trig_i,
    input  logic                       req_i,
    input  logic                       atomic_i,
    input  logic [idx_w(NUM_CNT)-1:0]  sel_i,
    output logic                       ack_o,
    output logic [BUS_W-1:0]           count_o,
    output logic                       err_o,
    output logic [NUM_CNT-1:0]         ovf_o,
    output logic                       dbg_state
);

    localparam int BEATS  = CNT_W / BUS_W;
    localparam int BEAT_W = idx_w(BEATS);
    localparam int SEL_W  = idx_w(NUM_CNT);

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]   snap_q, snap_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [BUS_W-1:0]   count_q, count_d;

    logic [CNT_W-1:0]   inc_val [NUM_CNT];
    logic [NUM_CNT-1:0] clr;
    logic               sel_ok;
    logic               atomic_hit;
    logic [CNT_W-1:0]   snap_next;
    logic [BUS_W-1:0]   slice;

    assign sel_ok     = ({1'b0, sel_i} < (SEL_W + 1)'(NUM_CNT));
    assign atomic_hit = req_i && atomic_i && sel_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_ch
            assign clr[gi] = atomic_hit && (sel_i == SEL_W'(gi));

            atomic_cnt_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .trig    (trig_i[gi]),
                .clr     (clr[gi]),
                .inc_val (inc_val[gi]),
                .ovf     (ovf_o[gi])
            );
        end
    endgenerate

    // Select the post-increment value of the addressed channel for the snapshot.
    always_comb begin
        snap_next = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel_i == SEL_W'(i)) begin
                snap_next = inc_val[i];
            end
        end
    end

    // Pick the snapshot slice addressed by the current beat index.
    always_comb begin
        slice = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                slice = snap_q[b*BUS_W +: BUS_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: atomic beats (re)start a read, a gap or the last beat ends it.
    always_comb begin
        state_d = state_q;
        if (req_i && atomic_i) begin
            state_d = (sel_ok && (BEATS > 1)) ? READ : IDLE;
        end else if (!req_i) begin
            state_d = IDLE;
        end else if ((state_q == READ) && (beat_q == BEAT_W'(BEATS - 1))) begin
            state_d = IDLE;
        end
    end

    // Beat response, snapshot and beat index for the coming edge.
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        beat_d  = beat_q;
        snap_d  = snap_q;
        if (req_i && atomic_i) begin
            ack_d = 1'b1;
            if (sel_ok) begin
                snap_d  = snap_next;
                count_d = snap_next[BUS_W-1:0];
                beat_d  = BEAT_W'(1);
            end else begin
                err_d   = 1'b1;
                count_d = '0;
                beat_d  = '0;
            end
        end else if (req_i) begin
            ack_d = 1'b1;
            if (state_q == READ) begin
                count_d = slice;
                beat_d  = beat_q + BEAT_W'(1);
            end else begin
                err_d   = 1'b1;
                count_d = '0;
            end
        end else begin
            beat_d = '0;
        end
    end

    // Registered response and read context.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            beat_q  <= '0;
            snap_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            count_q <= count_d;
            beat_q  <= beat_d;
            snap_q  <= snap_d;
        end
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign count_o   = count_q;
    assign dbg_state = state_q;

endmodule
